// File: rtl/gpu_cmd_scheduler_if.sv
// Host command / pixel-generator instruction bundle for gpu_cmd_scheduler.
// The master modport is the host side; the slave modport is the scheduler.
interface gpu_cmd_scheduler_if #(
  parameter int unsigned FIFO_DEPTH = 16
) ();
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     i_cmd;
  logic            i_cmd_valid;
  logic            o_cmd_ready;
  logic            i_vblank;
  logic [31:0]     o_instruction;
  logic            o_instruction_ready;
  logic [LvlW-1:0] o_fifo_level;
  logic            o_busy;
  logic            o_bad_opcode;

  modport master (
    output i_cmd, i_cmd_valid, i_vblank,
    input  o_cmd_ready, o_instruction, o_instruction_ready, o_fifo_level, o_busy, o_bad_opcode
  );

  modport slave (
    input  i_cmd, i_cmd_valid, i_vblank,
    output o_cmd_ready, o_instruction, o_instruction_ready, o_fifo_level, o_busy, o_bad_opcode
  );
endinterface

// File: rtl/gpu_cmd_scheduler.sv
// Buffers host commands in a show-ahead FIFO and issues them in order as one-cycle strobes,
// with an opcode-dependent quiet gap and optional vblank gating of screen-memory writes.
module gpu_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SPRITE_GAP = 8,
  parameter int unsigned PIXEL_GAP  = 1,
  parameter bit          BLANK_ONLY = 1'b1
) (
  input logic                i_clk,
  input logic                i_reset,
  gpu_cmd_scheduler_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned GapW = 16;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [1:0]      state_q, state_d;
  logic [31:0]     hold_q, hold_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            bad_q, bad_d;

  logic            push, pop;
  logic [31:0]     head;
  logic [3:0]      head_op, hold_op;
  logic            head_illegal, head_slow, head_eligible;
  logic [GapW-1:0] issue_gap;

  assign head          = mem_q[rd_ptr_q];
  assign head_op       = head[3:0];
  assign head_illegal  = (head_op == 4'h0) || (head_op > 4'h8);
  assign head_slow     = (head_op == 4'h7) || (head_op == 4'h8);
  assign head_eligible = !head_slow || !BLANK_ONLY || bus.i_vblank;
  assign hold_op       = hold_q[3:0];
  assign push          = bus.i_cmd_valid && bus.o_cmd_ready;

  always_comb begin
    issue_gap = '0;
    if (hold_op == 4'h8) begin
      issue_gap = GapW'(SPRITE_GAP);
    end else if (hold_op == 4'h7) begin
      issue_gap = GapW'(PIXEL_GAP);
    end
  end

  // vblank only matters here in IDLE; a popped command always completes its issue and gap.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    bad_d   = bad_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (level_q != '0) begin
          if (head_illegal) begin
            pop   = 1'b1;
            bad_d = 1'b1;
          end else if (head_eligible) begin
            pop     = 1'b1;
            hold_d  = head;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        gap_d   = issue_gap;
        state_d = (issue_gap != '0) ? StGap : StIdle;
      end
      StGap: begin
        gap_d = gap_q - GapW'(1);
        if (gap_q <= GapW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= StIdle;
      hold_q   <= '0;
      gap_q    <= '0;
      bad_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      bad_q    <= bad_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.i_cmd;
    end
  end

  assign bus.o_cmd_ready         = (level_q != LvlW'(FIFO_DEPTH));
  assign bus.o_instruction_ready = (state_q == StIssue);
  assign bus.o_instruction       = (state_q == StIssue) ? hold_q : 32'h0;
  assign bus.o_fifo_level        = level_q;
  assign bus.o_busy              = (state_q != StIdle) || (level_q != '0);
  assign bus.o_bad_opcode        = bad_q;
endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Bench for gpu_cmd_scheduler: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a timestamp-based queue model of the issue rules.
module tb_gpu_cmd_scheduler;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SGAP  = 8;
  localparam int unsigned PGAP  = 1;
  localparam bit          BLANK = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpu_cmd_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

  gpu_cmd_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .SPRITE_GAP(SGAP),
    .PIXEL_GAP (PGAP),
    .BLANK_ONLY(BLANK)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: pending commands, the cycle from which the scheduler is idle again,
  // and the cycle/word of the next expected strobe.
  logic [31:0] mq[$];
  int          idle_from   = 0;
  int          strobe_at   = -1;
  logic [31:0] strobe_word = '0;
  logic        m_bad       = 1'b0;
  bit          last_accept = 1'b0;

  int          sc[$];
  logic [31:0] sw[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int gap_of(input logic [3:0] op);
    if (op == 4'h8) return int'(SGAP);
    if (op == 4'h7) return int'(PGAP);
    return 0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    idle_from   = cyc;
    strobe_at   = -1;
    strobe_word = '0;
    m_bad       = 1'b0;
    last_accept = 1'b0;
  endfunction

  task automatic step(input logic v, input logic [31:0] c, input logic vb);
    bit         exp_stb;
    bit         pushed;
    logic [3:0] op;
    @(negedge clk);
    bus.i_cmd_valid = v;
    bus.i_cmd       = c;
    bus.i_vblank    = vb;
    #1;
    exp_stb = (strobe_at == cyc);
    check_eq("strobe", 32'(bus.o_instruction_ready), 32'(exp_stb));
    check_eq("instr", bus.o_instruction, exp_stb ? strobe_word : 32'h0);
    check_eq("level", 32'(bus.o_fifo_level), 32'(mq.size()));
    check_eq("ready", 32'(bus.o_cmd_ready), 32'(mq.size() != int'(DEPTH)));
    check_eq("busy", 32'(bus.o_busy), 32'((cyc < idle_from) || (mq.size() != 0)));
    check_eq("bad", 32'(bus.o_bad_opcode), 32'(m_bad));
    if (bus.o_instruction_ready) begin
      sc.push_back(cyc);
      sw.push_back(bus.o_instruction);
    end
    pushed = v && (mq.size() < int'(DEPTH));
    if (cyc >= idle_from && mq.size() != 0) begin
      op = mq[0][3:0];
      if (op == 4'h0 || op > 4'h8) begin
        void'(mq.pop_front());
        m_bad = 1'b1;
      end else if ((op != 4'h7 && op != 4'h8) || !BLANK || vb) begin
        strobe_word = mq.pop_front();
        strobe_at   = cyc + 1;
        idle_from   = cyc + 2 + gap_of(op);
      end
    end
    if (pushed) mq.push_back(c);
    last_accept = pushed;
    cyc++;
  endtask

  task automatic idle(input int n, input logic vb);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, vb);
  endtask

  // Reset asserted between clock edges; outputs must drop without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_strobe", 32'(bus.o_instruction_ready), 32'h0);
    check_eq("rst_instr", bus.o_instruction, 32'h0);
    check_eq("rst_level", 32'(bus.o_fifo_level), 32'h0);
    check_eq("rst_ready", 32'(bus.o_cmd_ready), 32'h1);
    check_eq("rst_busy", 32'(bus.o_busy), 32'h0);
    check_eq("rst_bad", 32'(bus.o_bad_opcode), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sc.delete();
    sw.delete();
  endtask

  initial begin
    logic [31:0] pushed_words[$];
    logic [31:0] cur_c;
    logic [31:0] tmp;
    logic [3:0]  op;
    logic        cur_v;
    logic        vb;
    int          c0;
    int          m;
    int          r;
    int          tries;

    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = '0;
    bus.i_vblank    = 1'b0;
    repeat (2) @(posedge clk);
    async_reset();

    // Basic latency: push at c0, strobe at c0+2.
    c0 = cyc;
    step(1'b1, 32'h0000_0F01, 1'b0);
    idle(4, 1'b0);
    check_eq("lat_cnt", 32'(sc.size()), 32'd1);
    if (sc.size() >= 1) begin
      check_eq("lat_cyc", 32'(sc[0] - c0), 32'd2);
      check_eq("lat_word", sw[0], 32'h0000_0F01);
    end

    // Sprite head blocks a BG command until vblank; spacing sprite->red is 10.
    async_reset();
    step(1'b1, 32'hAB12_0308, 1'b0);
    step(1'b1, 32'h0000_0002, 1'b0);
    idle(6, 1'b0);
    check_eq("blk_none", 32'(sc.size()), 32'd0);
    m = cyc;
    idle(16, 1'b1);
    check_eq("blk_cnt", 32'(sc.size()), 32'd2);
    if (sc.size() >= 2) begin
      check_eq("blk_spr", 32'(sc[0] - m), 32'd1);
      check_eq("blk_red", 32'(sc[1] - m), 32'd11);
    end

    // Fill with 17 pixel commands; the 17th waits for the first pop.
    async_reset();
    pushed_words.delete();
    for (int i = 0; i < 16; i++) begin
      tmp = 32'h0000_0007 | (32'(i) << 8);
      pushed_words.push_back(tmp);
      step(1'b1, tmp, 1'b0);
    end
    tmp = 32'h0000_1107;
    pushed_words.push_back(tmp);
    for (int i = 0; i < 5; i++) step(1'b1, tmp, 1'b0);
    check_eq("full_ready", 32'(bus.o_cmd_ready), 32'h0);
    tries = 0;
    do begin
      step(1'b1, tmp, 1'b1);
      tries++;
    end while (!last_accept && tries < 40);
    check_eq("full_accept", 32'(last_accept), 32'h1);
    idle(80, 1'b1);
    check_eq("full_cnt", 32'(sc.size()), 32'd17);
    for (int i = 0; i < 17 && i < sc.size(); i++) check_eq("full_order", sw[i], pushed_words[i]);

    // Illegal opcode is discarded and flagged.
    async_reset();
    step(1'b1, 32'h0000_000C, 1'b0);
    step(1'b1, 32'h0000_0005, 1'b0);
    idle(5, 1'b0);
    check_eq("ill_bad", 32'(bus.o_bad_opcode), 32'h1);
    check_eq("ill_cnt", 32'(sc.size()), 32'd1);
    if (sc.size() >= 1) check_eq("ill_word", sw[0], 32'h0000_0005);

    // vblank drops at the sprite issue; the queued pixel waits for vblank to return.
    async_reset();
    step(1'b1, 32'h0000_4408, 1'b1);
    step(1'b1, 32'h0000_5507, 1'b1);
    idle(15, 1'b0);
    check_eq("vb_first", 32'(sc.size()), 32'd1);
    idle(5, 1'b1);
    check_eq("vb_second", 32'(sc.size()), 32'd2);

    // Async reset mid-gap with 5 entries queued.
    async_reset();
    step(1'b1, 32'h0000_0008, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_0011 + 32'(i << 4), 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check_eq("mid_level", 32'(bus.o_fifo_level), 32'd5);
    async_reset();
    idle(20, 1'b1);
    check_eq("mid_none", 32'(sc.size()), 32'd0);

    // Randomized traffic with host-side hold on backpressure.
    async_reset();
    cur_v = 1'b0;
    cur_c = '0;
    vb    = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!(cur_v && !last_accept)) begin
        cur_v = ($urandom_range(0, 9) < 6);
        r     = int'($urandom_range(0, 9));
        if (r < 5 || r == 9) op = 4'($urandom_range(1, 6));
        else if (r < 7)      op = 4'h7;
        else if (r == 7)     op = 4'h8;
        else begin
          op = 4'($urandom_range(9, 16));
        end
        tmp   = $urandom();
        tmp[3:0] = op;
        cur_c = tmp;
      end
      if ($urandom_range(0, 19) == 0) vb = !vb;
      step(cur_v, cur_c, vb);
    end
    idle(250, 1'b1);
    check_eq("drain_level", 32'(bus.o_fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
